pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//  Shares the single physical-memory (cacheline) port between the I-cache and the D-cache.
//  Sits between both caches and the cacheline adaptor.
//  Grants one cache at a time, registers the granted address/data, and forwards the response.
//  Round-robin on contention; counts contention cycles for performance analysis.
// PARAMETERS
//  ADDR_W  32   physical address width
//  LINE_W  256  cacheline width
//  CNT_W   16   width of saturating contention counter
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-low (0 = reset)
//  i_read        in   1       I-cache line read request
//  i_addr        in   ADDR_W  I-cache line address
//  i_rdata       out  LINE_W  line returned to I-cache
//  i_resp        out  1       I-cache transaction complete
//  d_read        in   1       D-cache line read request
//  d_write       in   1       D-cache line write-back request
//  d_addr        in   ADDR_W  D-cache line address
//  d_wdata       in   LINE_W  D-cache write-back line
//  d_rdata       out  LINE_W  line returned to D-cache
//  d_resp        out  1       D-cache transaction complete
//  pmem_read     out  1       memory read strobe
//  pmem_write    out  1       memory write strobe
//  pmem_addr     out  ADDR_W  memory address
//  pmem_wdata    out  LINE_W  memory write line
//  pmem_rdata    in   LINE_W  memory read line
//  pmem_resp     in   1       memory transaction complete
//  busy          out  1       1 while any grant is active
//  conflict_cnt  out  CNT_W   saturating count of contention cycles in IDLE
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - state=IDLE; last_grant=I.
//    - pmem_read/pmem_write/i_resp/d_resp/busy = 0.
//    - pmem_addr/pmem_wdata = 0; conflict_cnt = 0.
//  - FSM states: IDLE, GRANT_I, GRANT_D.
//  - Requests: i_req = i_read; d_req = d_read | d_write.
//    - d_read & d_write together is illegal; treated as a write.
//  - IDLE transitions:
//    - only i_req -> GRANT_I.
//    - only d_req -> GRANT_D.
//    - both -> grant the opposite of last_grant, and conflict_cnt += 1 (saturates at all-ones).
//    - neither -> stay in IDLE.
//  - On a grant edge:
//    - register pmem_addr (and pmem_wdata for a D write) from the winner.
//    - update last_grant.
//    - pmem_read/pmem_write are registered and assert in the first GRANT cycle.
//    - Latency from request to strobe is 1 cycle.
//  - Grant hold:
//    - GRANT_x holds the strobe, addr and wdata stable until pmem_resp=1.
//    - Requester inputs are ignored while granted.
//  - Response:
//    - x_resp = pmem_resp & (state==GRANT_x), combinational, same cycle as pmem_resp.
//    - The strobe deasserts and the state returns to IDLE on the next edge.
//    - The other cache's resp is never asserted.
//  - i_rdata and d_rdata are both driven from pmem_rdata at all times; only resp qualifies them.
//  - Minimum one IDLE cycle between transactions; the caches drop their request the cycle after resp.
//  - pmem_resp in IDLE is ignored; it has no effect on the outputs.
//  - busy = (state != IDLE).
//  - Reset mid-transaction: abandon immediately to IDLE; no resp is issued. Memory is reset by the same rst.
// TESTING
//  - Reset with all inputs 1 -> all strobes/resp 0, pmem_addr=0, conflict_cnt=0, busy=0.
//  - I-cache read:
//    - i_read=1, i_addr=0x0000_1040 at cycle 0 -> pmem_read=1, pmem_addr=0x1040 at cycle 1.
//    - pmem_resp at cycle 5 -> i_resp=1 at cycle 5 and pmem_read=0 at cycle 6.
//  - Simultaneous d_write (addr 0x2000, wdata 0xA5 repeated) and i_read after reset:
//    - D is granted first (last_grant=I); pmem_write=1 with wdata 0xA5.., conflict_cnt=1.
//    - After d_resp, I is granted.
//  - Alternation: both requesting continuously for 4 transactions -> grant order D,I,D,I; conflict_cnt=4.
//  - Drop rst mid GRANT_D (before pmem_resp) -> pmem_write=0 asynchronously, no d_resp.
//    After reset release, a new i_read is served normally.
//  - CNT_W=2 with 5 contention events -> conflict_cnt saturates at 3.

Source files
------------

// File: rtl/pmem_arbiter_if.sv
// Cache-side and memory-side signals of the physical-memory arbiter.
// The arbiter takes the slave view; the surrounding caches and memory drive the master view.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              busy;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
           pmem_wdata, busy, conflict_cnt
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
           pmem_wdata, busy, conflict_cnt
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache and D-cache,
// with a saturating counter of cycles where both caches contend in IDLE.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  pmem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  logic [1:0]        state;
  logic              last_d;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [CNT_W-1:0]  conflict_cnt;
  logic              i_req;
  logic              d_req;
  logic              pick_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // On contention the side that did not win last time goes next.
  always_comb begin
    pick_d = d_req & (~i_req | ~last_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_d       <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_addr    <= '0;
      pmem_wdata   <= '0;
      conflict_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && d_req && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (pick_d) begin
            state     <= GRANT_D;
            last_d    <= 1'b1;
            pmem_addr <= bus.d_addr;
            // A simultaneous read and write request is served as a write.
            if (bus.d_write) begin
              pmem_write <= 1'b1;
              pmem_wdata <= bus.d_wdata;
            end else begin
              pmem_read  <= 1'b1;
            end
          end else if (i_req) begin
            state     <= GRANT_I;
            last_d    <= 1'b0;
            pmem_addr <= bus.i_addr;
            pmem_read <= 1'b1;
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pmem_read    = pmem_read;
  assign bus.pmem_write   = pmem_write;
  assign bus.pmem_addr    = pmem_addr;
  assign bus.pmem_wdata   = pmem_wdata;
  assign bus.conflict_cnt = conflict_cnt;
  assign bus.busy         = (state != IDLE);
  assign bus.i_resp       = bus.pmem_resp & (state == GRANT_I);
  assign bus.d_resp       = bus.pmem_resp & (state == GRANT_D);
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a vector table for single-cycle behaviour plus
// hand sequences for alternation, mid-grant reset and counter saturation.
module tb_pmem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pmem_arbiter_if #(.ADDR_W(32), .LINE_W(256), .CNT_W(16)) bus ();
  pmem_arbiter_if #(.ADDR_W(32), .LINE_W(256), .CNT_W(2))  bus2 ();

  pmem_arbiter #(.ADDR_W(32), .LINE_W(256), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  pmem_arbiter #(.ADDR_W(32), .LINE_W(256), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ir;
    logic [31:0]  ia;
    logic         dr;
    logic         dw;
    logic [31:0]  da;
    logic [255:0] wd;
    logic         resp;
    logic         e_pr;
    logic         e_pw;
    logic [31:0]  e_addr;
    logic [255:0] e_wd;
    logic         e_ir;
    logic         e_dr;
    logic         e_busy;
    logic [15:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [255:0] wd, logic resp,
                              logic epr, logic epw, logic [31:0] ea, logic [255:0] ew,
                              logic eir, logic edr, logic eb, logic [15:0] ec);
    vec_t v;
    v.rst = r;   v.ir = ir;   v.ia = ia;   v.dr = dr;   v.dw = dw;
    v.da = da;   v.wd = wd;   v.resp = resp;
    v.e_pr = epr; v.e_pw = epw; v.e_addr = ea; v.e_wd = ew;
    v.e_ir = eir; v.e_dr = edr; v.e_busy = eb; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_read = 1'b0; bus.i_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.d_addr = '0;   bus.d_wdata = '0; bus.pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t         tbl[$];
  logic [255:0] a5;
  logic [255:0] ones;
  logic [255:0] rd;
  logic [31:0]  ia_exp;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a5    = {32{8'hA5}};
    ones  = '1;
    drive_idle();
    bus.pmem_rdata = '0;
    bus2.i_read = 1'b0; bus2.i_addr = '0; bus2.d_read = 1'b0; bus2.d_write = 1'b0;
    bus2.d_addr = '0;   bus2.d_wdata = '0; bus2.pmem_rdata = '0; bus2.pmem_resp = 1'b0;

    // reset with every input high, then a plain I-cache read
    tbl.push_back(mk(0,1,32'hFFFF_FFFF,1,1,32'hFFFF_FFFF,ones,1, 0,0,32'h0,0,0,0,0,16'd0));
    tbl.push_back(mk(0,1,32'hFFFF_FFFF,1,1,32'hFFFF_FFFF,ones,1, 0,0,32'h0,0,0,0,0,16'd0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,                         0,0,32'h0,0,0,0,0,16'd0));
    tbl.push_back(mk(1,1,32'h0000_1040,0,0,0,0,0,             0,0,32'h0,0,0,0,0,16'd0));
    tbl.push_back(mk(1,1,32'h0000_1040,0,0,0,0,0,             1,0,32'h1040,0,0,0,1,16'd0));
    tbl.push_back(mk(1,1,32'hDEAD_0000,0,1,32'h7000,a5,0,     1,0,32'h1040,0,0,0,1,16'd0));
    tbl.push_back(mk(1,1,32'h0000_1040,0,0,0,0,0,             1,0,32'h1040,0,0,0,1,16'd0));
    tbl.push_back(mk(1,1,32'h0000_1040,0,0,0,0,0,             1,0,32'h1040,0,0,0,1,16'd0));
    tbl.push_back(mk(1,1,32'h0000_1040,0,0,0,0,1,             1,0,32'h1040,0,1,0,1,16'd0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,                         0,0,32'h1040,0,0,0,0,16'd0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,                         0,0,32'h1040,0,0,0,0,16'd0));
    // contention after reset: D wins first, then I
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                         0,0,32'h0,0,0,0,0,16'd0));
    tbl.push_back(mk(1,1,32'h3000,0,1,32'h2000,a5,0,          0,0,32'h0,0,0,0,0,16'd0));
    tbl.push_back(mk(1,1,32'h3000,0,1,32'h2000,a5,0,          0,1,32'h2000,a5,0,0,1,16'd1));
    tbl.push_back(mk(1,1,32'h3000,0,1,32'h2000,a5,1,          0,1,32'h2000,a5,0,1,1,16'd1));
    tbl.push_back(mk(1,1,32'h3000,0,0,0,0,0,                  0,0,32'h2000,a5,0,0,0,16'd1));
    tbl.push_back(mk(1,1,32'h3000,0,0,0,0,0,                  1,0,32'h3000,a5,0,0,1,16'd1));
    tbl.push_back(mk(1,1,32'h3000,0,0,0,0,1,                  1,0,32'h3000,a5,1,0,1,16'd1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,                         0,0,32'h3000,a5,0,0,0,16'd1));

    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst;
      bus.i_read = tbl[k].ir;  bus.i_addr = tbl[k].ia;
      bus.d_read = tbl[k].dr;  bus.d_write = tbl[k].dw;
      bus.d_addr = tbl[k].da;  bus.d_wdata = tbl[k].wd;
      bus.pmem_resp = tbl[k].resp;
      rd = {8{32'hC0DE_0000 + 32'(k)}};
      bus.pmem_rdata = rd;
      #1;
      chk($sformatf("v%0d pmem_read", k),  256'(bus.pmem_read),    256'(tbl[k].e_pr));
      chk($sformatf("v%0d pmem_write", k), 256'(bus.pmem_write),   256'(tbl[k].e_pw));
      chk($sformatf("v%0d pmem_addr", k),  256'(bus.pmem_addr),    256'(tbl[k].e_addr));
      chk($sformatf("v%0d pmem_wdata", k), bus.pmem_wdata,         tbl[k].e_wd);
      chk($sformatf("v%0d i_resp", k),     256'(bus.i_resp),       256'(tbl[k].e_ir));
      chk($sformatf("v%0d d_resp", k),     256'(bus.d_resp),       256'(tbl[k].e_dr));
      chk($sformatf("v%0d busy", k),       256'(bus.busy),         256'(tbl[k].e_busy));
      chk($sformatf("v%0d conflict_cnt", k), 256'(bus.conflict_cnt), 256'(tbl[k].e_cnt));
      chk($sformatf("v%0d i_rdata", k),    bus.i_rdata,            rd);
      chk($sformatf("v%0d d_rdata", k),    bus.d_rdata,            rd);
    end

    // both caches request continuously: grants alternate D, I, D, I
    do_reset();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      bus.i_read = 1'b1; bus.i_addr = 32'h5000;
      bus.d_read = 1'b1; bus.d_write = 1'b0; bus.d_addr = 32'h4000;
      bus.pmem_resp = 1'b0;
      #1;
      chk($sformatf("alt%0d idle busy", t), 256'(bus.busy), 256'(1'b0));
      @(negedge clk);
      bus.pmem_resp = 1'b1;
      #1;
      ia_exp = (t % 2 == 0) ? 32'h4000 : 32'h5000;
      chk($sformatf("alt%0d addr", t),   256'(bus.pmem_addr), 256'(ia_exp));
      chk($sformatf("alt%0d read", t),   256'(bus.pmem_read), 256'(1'b1));
      chk($sformatf("alt%0d d_resp", t), 256'(bus.d_resp),    256'(t % 2 == 0));
      chk($sformatf("alt%0d i_resp", t), 256'(bus.i_resp),    256'(t % 2 == 1));
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("alt conflict_cnt", 256'(bus.conflict_cnt), 256'(16'd4));

    // reset dropped in the middle of a D write grant
    do_reset();
    @(negedge clk);
    bus.d_write = 1'b1; bus.d_addr = 32'h6000; bus.d_wdata = a5;
    @(negedge clk);
    #1;
    chk("mid pmem_write before", 256'(bus.pmem_write), 256'(1'b1));
    @(posedge clk);
    #2;
    bus.pmem_resp = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid pmem_write async", 256'(bus.pmem_write), 256'(1'b0));
    chk("mid d_resp",           256'(bus.d_resp),     256'(1'b0));
    chk("mid busy",             256'(bus.busy),       256'(1'b0));
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    bus.i_read = 1'b1; bus.i_addr = 32'h8000;
    @(negedge clk);
    #1;
    chk("post pmem_read", 256'(bus.pmem_read), 256'(1'b1));
    chk("post pmem_addr", 256'(bus.pmem_addr), 256'(32'h8000));
    bus.pmem_resp = 1'b1;
    #1;
    chk("post i_resp", 256'(bus.i_resp), 256'(1'b1));
    chk("post d_resp", 256'(bus.d_resp), 256'(1'b0));
    @(negedge clk);
    drive_idle();
    #1;
    chk("post read drop", 256'(bus.pmem_read), 256'(1'b0));

    // narrow counter: five contention events saturate at 3
    do_reset();
    bus2.i_read = 1'b1; bus2.i_addr = 32'h100;
    bus2.d_read = 1'b1; bus2.d_addr = 32'h200;
    bus2.pmem_resp = 1'b1;
    @(negedge clk);
    #1;
    chk("sat cnt after 1", 256'(bus2.conflict_cnt), 256'(2'd1));
    repeat (9) @(negedge clk);
    #1;
    chk("sat cnt after 5", 256'(bus2.conflict_cnt), 256'(2'd3));
    bus2.i_read = 1'b0; bus2.d_read = 1'b0; bus2.pmem_resp = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
